// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a downstream 16:1 mux: walks the enabled channels in
// ascending order, waits SETTLE cycles on each select value, then captures Y.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] ch_mask,
  input  logic        y_in,
  output logic [3:0]  sel,
  output logic [15:0] sample,
  output logic [4:0]  cap_cnt,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CH_N = 16;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned SETTLE_W = 4;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CH_N-1:0]     mask_q, mask_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SEL_W-1:0]    sel_d;
  logic [CH_N-1:0]     sample_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                busy_d, done_d;

  logic                low_found, nxt_found;
  logic [SEL_W-1:0]    low_idx, nxt_idx;

  // Lowest enabled channel of the incoming mask, and next enabled channel above sel
  always_comb begin
    low_found = 1'b0;
    low_idx   = '0;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = CH_N - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        low_found = 1'b1;
        low_idx   = SEL_W'(i);
      end
      if (mask_q[i] && (i > int'(sel))) begin
        nxt_found = 1'b1;
        nxt_idx   = SEL_W'(i);
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    settle_d = settle_q;
    sel_d    = sel;
    sample_d = sample;
    cnt_d    = cap_cnt;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d   = ch_mask;
          sample_d = '0;
          cnt_d    = '0;
          settle_d = '0;
          if (low_found) begin
            state_d = S_SETTLE;
            sel_d   = low_idx;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SETTLE: begin
        settle_d = settle_q + SETTLE_W'(1);
        if (settle_q == SETTLE_LAST) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        sample_d[sel] = y_in;
        cnt_d         = cap_cnt + CNT_W'(1);
        if (nxt_found) begin
          sel_d    = nxt_idx;
          settle_d = '0;
          state_d  = S_SETTLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      settle_q <= '0;
      sel      <= '0;
      sample   <= '0;
      cap_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      settle_q <= settle_d;
      sel      <= sel_d;
      sample   <= sample_d;
      cap_cnt  <= cnt_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: one instance with SETTLE=1 and one
// with SETTLE=3, each driving a behavioural 16:1 mux built from a pattern word.
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start3;
  logic [15:0] ch_mask;
  logic [15:0] pat;
  logic        y1, y3;
  logic [3:0]  sel1, sel3;
  logic [15:0] sample1, sample3;
  logic [4:0]  cnt1, cnt3;
  logic        busy1, busy3, done1, done3;

  logic        w;
  logic        done_m, busy_m;
  logic [3:0]  sel_m;
  logic [15:0] sample_m;
  logic [4:0]  cnt_m;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign y1 = pat[sel1];
  assign y3 = pat[sel3];

  assign done_m   = w ? done3   : done1;
  assign busy_m   = w ? busy3   : busy1;
  assign sel_m    = w ? sel3    : sel1;
  assign sample_m = w ? sample3 : sample1;
  assign cnt_m    = w ? cnt3    : cnt1;

  mux_scan_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ch_mask(ch_mask), .y_in(y1),
    .sel(sel1), .sample(sample1), .cap_cnt(cnt1), .busy(busy1), .done(done1)
  );

  mux_scan_sequencer #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .ch_mask(ch_mask), .y_in(y3),
    .sel(sel3), .sample(sample3), .cap_cnt(cnt3), .busy(busy3), .done(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full scan on the selected instance, checked against a mask/pattern model
  task automatic run_scan(input logic which, input logic [15:0] mask,
                          input logic [15:0] pat_i, input string tag);
    int         c;
    int         n;
    int         settle;
    logic [3:0] sel_before;
    logic [3:0] seen[$];
    logic [3:0] expv[$];
    w          = which;
    pat        = pat_i;
    ch_mask    = mask;
    settle     = which ? 3 : 1;
    n          = $countones(mask);
    sel_before = sel_m;
    for (int i = 0; i < 16; i++) if (mask[i]) expv.push_back(4'(i));
    if (which) start3 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
    c = 1;
    while (!done_m && c < 200) begin
      if (busy_m && (seen.size() == 0 || seen[$] != sel_m)) seen.push_back(sel_m);
      tick();
      c++;
    end
    check({tag, "_latency"}, 32'(c), 32'(1 + n * (settle + 1)));
    check({tag, "_done"},    32'(done_m), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy_m), 32'd0);
    check({tag, "_sample"},  32'(sample_m), 32'(mask & pat_i));
    check({tag, "_cap_cnt"}, 32'(cnt_m), 32'(n));
    check({tag, "_visits"},  32'(seen.size()), 32'(expv.size()));
    for (int i = 0; i < seen.size() && i < expv.size(); i++)
      check({tag, "_visit_order"}, 32'(seen[i]), 32'(expv[i]));
    if (mask == 16'h0) check({tag, "_sel_held"}, 32'(sel_m), 32'(sel_before));
    tick();
    check({tag, "_done_pulse"}, 32'(done_m), 32'd0);
  endtask

  initial begin
    int c;
    int dones;
    int first;
    int last_done;
    int periods;

    rst_n   = 1'b0;
    start1  = 1'b1;
    start3  = 1'b1;
    ch_mask = 16'hFFFF;
    pat     = 16'h0;
    w       = 1'b0;
    tick();
    tick();
    check("rst_sel1",    32'(sel1),    32'd0);
    check("rst_sample1", 32'(sample1), 32'd0);
    check("rst_cnt1",    32'(cnt1),    32'd0);
    check("rst_busy1",   32'(busy1),   32'd0);
    check("rst_done1",   32'(done1),   32'd0);
    check("rst_busy3",   32'(busy3),   32'd0);
    check("rst_done3",   32'(done3),   32'd0);
    start1 = 1'b0;
    start3 = 1'b0;
    rst_n  = 1'b1;
    tick();

    run_scan(1'b0, 16'hFFFF, 16'hA5C3, "full");
    run_scan(1'b1, 16'h8001, 16'hFFFF, "sparse");
    run_scan(1'b0, 16'h0000, 16'hFFFF, "empty");

    // Start pulses and mask changes while busy must not disturb the scan
    w       = 1'b0;
    pat     = 16'h0050;
    ch_mask = 16'h00F0;
    start1  = 1'b1;
    tick();
    dones = 0;
    first = 0;
    for (int i = 1; i <= 30; i++) begin
      if (done1) begin
        dones++;
        if (first == 0) first = i;
      end
      start1  = busy1 ? ~start1 : 1'b0;
      ch_mask = 16'($urandom);
      tick();
    end
    check("ignore_done_count", 32'(dones), 32'd1);
    check("ignore_latency",    32'(first), 32'd9);
    check("ignore_idle",       32'(busy1), 32'd0);
    check("ignore_sample_hold", 32'(sample1), 32'h0050);
    check("ignore_cnt_hold",   32'(cnt1), 32'd4);

    // Reset after five captures aborts the scan; start during reset is dropped
    pat     = 16'h1234;
    ch_mask = 16'hFFFF;
    start1  = 1'b1;
    tick();
    start1 = 1'b0;
    c = 1;
    while (cnt1 != 5'd5 && c < 100) begin
      tick();
      c++;
    end
    check("midrst_reach5", 32'(cnt1), 32'd5);
    rst_n  = 1'b0;
    start1 = 1'b1;
    tick();
    rst_n  = 1'b1;
    start1 = 1'b0;
    check("midrst_sel",    32'(sel1),    32'd0);
    check("midrst_sample", 32'(sample1), 32'd0);
    check("midrst_cnt",    32'(cnt1),    32'd0);
    check("midrst_busy",   32'(busy1),   32'd0);
    check("midrst_done",   32'(done1),   32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done1 || busy1) dones++;
      tick();
    end
    check("midrst_quiet", 32'(dones), 32'd0);
    run_scan(1'b0, 16'hFFFF, 16'h3C5A, "after_rst");

    // Start held high: back-to-back scans every 6 cycles, sample cleared each time
    w       = 1'b0;
    pat     = 16'h0002;
    ch_mask = 16'h0003;
    start1  = 1'b1;
    tick();
    first     = 0;
    last_done = 0;
    periods   = 0;
    for (int i = 1; i <= 25; i++) begin
      if (done1) begin
        if (first == 0) begin
          first = i;
          check("b2b_first_latency", 32'(i), 32'd5);
        end else begin
          check("b2b_period", 32'(i - last_done), 32'd6);
          periods++;
        end
        check("b2b_sample", 32'(sample1), 32'h0002);
        check("b2b_cnt",    32'(cnt1),    32'd2);
        last_done = i;
      end
      if (last_done != 0 && i == last_done + 2) begin
        check("b2b_sample_cleared", 32'(sample1), 32'h0);
        check("b2b_cnt_cleared",    32'(cnt1),    32'd0);
      end
      tick();
    end
    check("b2b_periods", 32'(periods), 32'd3);
    start1 = 1'b0;
    c = 0;
    while (!done1 && c < 50) begin
      tick();
      c++;
    end
    tick();
    tick();
    check("b2b_stop_idle", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
